// File: rtl/jtag_rfifo_rd_arbiter_if.sv
// FIFO read-port bundle between the read arbiter (master) and the FIFO read pointer/memory plus consumers (slave).
// Widths follow NREQ / DATA_WIDTH, so both ends must be built with matching parameters.
interface jtag_rfifo_rd_arbiter_if #(
  parameter int NREQ       = 2,
  parameter int DATA_WIDTH = 32
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic                  empty;
  logic [DATA_WIDTH-1:0] rdata;
  logic [NREQ-1:0]       req;
  logic                  rinc;
  logic [NREQ-1:0]       gnt;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [IW-1:0]         rd_id;
  logic                  busy;

  modport master (
    input  empty, rdata, req,
    output rinc, gnt, rd_valid, rd_data, rd_id, busy
  );

  modport slave (
    output empty, rdata, req,
    input  rinc, gnt, rd_valid, rd_data, rd_id, busy
  );
endinterface

// File: rtl/jtag_rfifo_rd_arbiter.sv
// Round-robin read arbiter for the JTAG async FIFO: 1-cycle arbitration, pop->rd_valid 1 cycle, bursts of <= MAX_BURST pops.
// No consumer backpressure: an owner pauses by dropping req (releases the grant); define JTAG_RARB_CNT_EN for the saturating pop_cnt output.
module jtag_rfifo_rd_arbiter #(
  parameter int NREQ       = 2,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                      rclk,
  input  logic                      r_rst,
`ifdef JTAG_RARB_CNT_EN
  output logic [15:0]               pop_cnt,
`endif
  jtag_rfifo_rd_arbiter_if.master   bus
);
  localparam int             IW         = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int             BW         = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0]  BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [IW-1:0]  LAST_RST   = IW'(NREQ - 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [IW-1:0]         owner;
  logic [IW-1:0]         last;
  logic [IW-1:0]         pick;
  logic [BW-1:0]         burst_cnt;
  logic                  pop;
  logic                  grant_start;
  logic                  release_burst;
  logic                  burst_done;
  logic                  found;
  int                    scan_idx;
  logic [NREQ-1:0]       gnt_c;
  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [IW-1:0]         rd_id_q;

  // Round-robin pick: scan last+1, last+2, ... wrapping, so the previous owner has lowest priority.
  always_comb begin
    found    = 1'b0;
    pick     = last;
    scan_idx = 0;
    for (int i = 1; i <= NREQ; i++) begin
      scan_idx = int'(last) + i;
      if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
      if (!found && bus.req[IW'(scan_idx)]) begin
        found = 1'b1;
        pick  = IW'(scan_idx);
      end
    end
  end

  always_ff @(posedge rclk or posedge r_rst) begin
    if (r_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    grant_start   = 1'b0;
    release_burst = 1'b0;
    burst_done    = 1'b0;
    case (state)
      IDLE: begin
        if ((|bus.req) && !bus.empty) begin
          grant_start = 1'b1;
          state_nxt   = GRANT;
        end
      end
      GRANT: begin
        burst_done = pop && (burst_cnt == BURST_LAST);
        if (burst_done || !bus.req[owner] || bus.empty) begin
          release_burst = 1'b1;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop   = 1'b0;
    gnt_c = '0;
    if (state == GRANT) begin
      pop          = bus.req[owner] & ~bus.empty;
      gnt_c[owner] = 1'b1;
    end
  end

  assign bus.rinc     = pop;
  assign bus.gnt      = gnt_c;
  assign bus.busy     = (state != IDLE);
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_id    = rd_id_q;

  always_ff @(posedge rclk or posedge r_rst) begin
    if (r_rst) begin
      owner     <= '0;
      last      <= LAST_RST;
      burst_cnt <= '0;
    end else begin
      if (grant_start) owner <= pick;
      if (release_burst) begin
        last      <= owner;
        burst_cnt <= '0;
      end else if (pop) begin
        burst_cnt <= burst_cnt + BW'(1);
      end
    end
  end

  // rd_data/rd_id hold their last popped value; only rd_valid marks a fresh word.
  always_ff @(posedge rclk or posedge r_rst) begin
    if (r_rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_id_q    <= '0;
    end else begin
      rd_valid_q <= pop;
      if (pop) begin
        rd_data_q <= bus.rdata;
        rd_id_q   <= owner;
      end
    end
  end

`ifdef JTAG_RARB_CNT_EN
  always_ff @(posedge rclk or posedge r_rst) begin
    if (r_rst)                           pop_cnt <= '0;
    else if (pop && pop_cnt != 16'hFFFF) pop_cnt <= pop_cnt + 16'd1;
  end
`endif

  a_gnt_onehot: assert property (@(posedge rclk) disable iff (r_rst) $onehot0(bus.gnt));
  a_burst_bound: assert property (@(posedge rclk) disable iff (r_rst) burst_cnt < BW'(MAX_BURST));

endmodule
